// File: rtl/product_accumulator.sv
// Sums COUNT unsigned 8-bit products into one ACC_W-bit result with a sticky
// per-group overflow flag; valid/ready handshakes on both input and output.
//
// state | meaning
// ACCUM | accepting products into the running sum
// HOLD  | completed result presented on out_sum/out_overflow
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int COUNT = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;
  logic             accept;
  logic             last;

  assign sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, in_product};
  assign accept  = in_valid && (state == ACCUM);
  assign last    = (cnt == CNT_W'(COUNT-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
    // clear outranks both handshakes, including a pending result
    if (clear) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_sum      <= '0;
      out_overflow <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      if (last) begin
        out_sum      <= sum_ext[ACC_W-1:0];
        out_overflow <= ovf | sum_ext[ACC_W];
        acc          <= '0;
        cnt          <= '0;
        ovf          <= 1'b0;
      end else begin
        acc <= sum_ext[ACC_W-1:0];
        ovf <= ovf | sum_ext[ACC_W];
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
